// File: rtl/incr_out_fifo.sv
// Output buffer for the registered incrementer: small synchronous FIFO with a
// valid/ready consumer port and a sticky overflow flag for dropped inputs.
module incr_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  input  logic [WIDTH-1:0] in,
  output logic             in_rdy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             push, pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_rdy   = !full;
  assign out_val  = !empty;
  assign count    = cnt;
  assign overflow = ovf;
  // Storage is never reset, so the head is gated to keep out at zero when empty.
  assign out      = empty ? '0 : mem[rd_ptr];

  assign pop  = out_val && out_rdy;
  assign push = in_val && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (in_val && !push) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_incr_out_fifo.sv
// Directed plus randomized bench for incr_out_fifo against a queue-based model.
module tb_incr_out_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_val = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             in_rdy;
  logic             out_val;
  logic             out_rdy = 1'b0;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             full, empty, overflow;

  int checks = 0;
  int failures = 0;

  incr_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in(din), .in_rdy(in_rdy),
    .out_val(out_val), .out_rdy(out_rdy), .out(dout), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue plus the sticky drop flag.
  logic [WIDTH-1:0] q[$];
  bit m_ovf = 0;
  bit chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf  = 0;
      chk_en = 1;
    end else begin
      bit p_pop, p_push;
      p_pop  = (q.size() != 0) && out_rdy;
      p_push = in_val && ((q.size() < DEPTH) || p_pop);
      if (in_val && !p_push) m_ovf = 1;
      if (p_pop) void'(q.pop_front());
      if (p_push) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic [WIDTH-1:0] e_out;
      n = q.size();
      e_out = (n != 0) ? q[0] : '0;
      check("m_out", 32'(dout), 32'(e_out));
      check("m_out_val", 32'(out_val), 32'(n != 0));
      check("m_count", 32'(count), 32'(n));
      check("m_full", 32'(full), 32'(n == DEPTH));
      check("m_empty", 32'(empty), 32'(n == 0));
      check("m_in_rdy", 32'(in_rdy), 32'(n != DEPTH));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] v);
    in_val = 1'b1;
    din    = v;
    cyc();
    in_val = 1'b0;
  endtask

  initial begin
    // Reset with live inputs that must be ignored.
    rst = 1'b1; in_val = 1'b1; din = 8'hAA; out_rdy = 1'b1;
    repeat (10) cyc();
    rst = 1'b0; in_val = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out", 32'(dout), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);

    // Single pass-through with a consumer that never stalls.
    out_rdy = 1'b1;
    in_val = 1'b1;
    din = 8'h01; cyc(); check("pt_out0", 32'(dout), 32'h01); check("pt_cnt0", 32'(count), 32'd1);
    din = 8'h14; cyc(); check("pt_out1", 32'(dout), 32'h14); check("pt_cnt1", 32'(count), 32'd1);
    din = 8'h28; cyc(); check("pt_out2", 32'(dout), 32'h28); check("pt_cnt2", 32'(count), 32'd1);
    in_val = 1'b0; cyc();
    check("pt_empty", 32'(empty), 32'd1);

    // Fill, stall, drop one, then drain.
    out_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(8'(8'h10 + i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_rdy", 32'(in_rdy), 32'd0);
    check("fill_count", 32'(count), 32'd4);
    push_one(8'h14);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    out_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_out", 32'(dout), 32'(8'h10 + i));
      cyc();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    rst = 1'b1; cyc(); rst = 1'b0;

    // Full with simultaneous push and pop.
    out_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(8'(8'h20 + i));
    out_rdy = 1'b1;
    push_one(8'h24);
    check("fpp_count", 32'(count), 32'd4);
    check("fpp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("fpp_out", 32'(dout), 32'(8'h21 + i));
      cyc();
    end
    check("fpp_empty", 32'(empty), 32'd1);

    // Pointer wrap-around.
    for (int it = 0; it < 10; it++) begin
      out_rdy = 1'b0;
      push_one(8'(2 * it));
      push_one(8'(2 * it + 1));
      out_rdy = 1'b1;
      check("wrap_out_a", 32'(dout), 32'(2 * it));
      cyc();
      check("wrap_out_b", 32'(dout), 32'(2 * it + 1));
      cyc();
    end
    check("wrap_count", 32'(count), 32'd0);

    // Reset mid-operation discards contents.
    out_rdy = 1'b0;
    push_one(8'h05); push_one(8'h06); push_one(8'h07);
    rst = 1'b1; in_val = 1'b1; din = 8'hEE; out_rdy = 1'b1; cyc();
    rst = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_out", 32'(dout), 32'h00);
    push_one(8'h08);
    check("mrst_first", 32'(dout), 32'h08);
    out_rdy = 1'b1; cyc();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      in_val  = ($urandom_range(0, 3) != 0);
      din     = 8'($urandom);
      out_rdy = ($urandom_range(0, 2) != 0) || (i % 400 > 300);
      if (i % 400 < 100) out_rdy = ($urandom_range(0, 4) == 0);
      cyc();
    end
    rst = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
